// File: rtl/writeback_queue.sv
// Writeback queue: 4-entry FIFO merging mem and ALU write requests into one register-file write port.
// Latency: an entry enqueued at one edge is written at the next edge at the earliest; write port is combinational from head.
// Backpressure: inReady drops when fewer than two slots are free; requests that arrive anyway are dropped and set sticky overflow.
// Optional forwarding lookup is built only with WRITEBACK_QUEUE_FORWARDING_EN.
module writeback_queue (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        memValid,
    input  logic [4:0]  memRd,
    input  logic [31:0] memData,
    input  logic        aluValid,
    input  logic [4:0]  aluRd,
    input  logic [31:0] aluData,
    input  logic        wbStall,
    output logic        inReady,
    output logic        regWrite,
    output logic [4:0]  writeRegId,
    output logic [31:0] writeData,
    output logic        overflow,
    input  logic [4:0]  readReg1,
    input  logic [4:0]  readReg2,
    output logic        fwdHit1,
    output logic        fwdHit2,
    output logic [31:0] fwdData1,
    output logic [31:0] fwdData2
);

    logic [4:0]  r_rd   [4];
    logic [31:0] r_data [4];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;
    logic        r_overflow;

    logic        w_mem_push;
    logic        w_alu_push;
    logic        w_drop;
    logic        w_pop;
    logic [1:0]  w_n_push;
    logic [1:0]  w_alu_idx;

    assign inReady    = (r_count <= 3'd2);
    assign w_mem_push = memValid && inReady && (memRd != 5'd0);
    assign w_alu_push = aluValid && inReady && (aluRd != 5'd0);
    assign w_drop     = !inReady && ((memValid && (memRd != 5'd0)) ||
                                     (aluValid && (aluRd != 5'd0)));
    assign w_n_push   = {1'b0, w_mem_push} + {1'b0, w_alu_push};
    // ALU request is the younger one, so it lands behind a same-cycle mem request.
    assign w_alu_idx  = w_mem_push ? (r_tail + 2'd1) : r_tail;

    assign regWrite   = (r_count != 3'd0) && !wbStall;
    assign w_pop      = regWrite;
    assign writeRegId = (r_count != 3'd0) ? r_rd[r_head]   : 5'd0;
    assign writeData  = (r_count != 3'd0) ? r_data[r_head] : 32'd0;
    assign overflow   = r_overflow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_rd[i]   <= 5'd0;
                r_data[i] <= 32'd0;
            end
        end else begin
            if (w_mem_push) begin
                r_rd[r_tail]   <= memRd;
                r_data[r_tail] <= memData;
            end
            if (w_alu_push) begin
                r_rd[w_alu_idx]   <= aluRd;
                r_data[w_alu_idx] <= aluData;
            end
            r_tail  <= r_tail + w_n_push;
            r_head  <= r_head + {1'b0, w_pop};
            r_count <= r_count + {1'b0, w_n_push} - {2'b00, w_pop};
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef WRITEBACK_QUEUE_FORWARDING_EN
    logic [1:0] w_idx;

    // Walk oldest to newest so the newest matching entry wins.
    always_comb begin
        fwdHit1  = 1'b0;
        fwdHit2  = 1'b0;
        fwdData1 = 32'd0;
        fwdData2 = 32'd0;
        w_idx    = r_head;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_head + i[1:0];
            if (3'(i) < r_count) begin
                if ((readReg1 != 5'd0) && (r_rd[w_idx] == readReg1)) begin
                    fwdHit1  = 1'b1;
                    fwdData1 = r_data[w_idx];
                end
                if ((readReg2 != 5'd0) && (r_rd[w_idx] == readReg2)) begin
                    fwdHit2  = 1'b1;
                    fwdData2 = r_data[w_idx];
                end
            end
        end
    end
`else
    logic w_unused_lookup;

    assign w_unused_lookup = ^{readReg1, readReg2};
    assign fwdHit1  = 1'b0;
    assign fwdHit2  = 1'b0;
    assign fwdData1 = 32'd0;
    assign fwdData2 = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed stimulus pushes expected writes into a scoreboard,
// a negedge monitor pops and compares every register-file write the DUT issues.
module tb_writeback_queue;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clock;
    logic        reset_n;
    logic        memValid;
    logic [4:0]  memRd;
    logic [31:0] memData;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        wbStall;
    logic        inReady;
    logic        regWrite;
    logic [4:0]  writeRegId;
    logic [31:0] writeData;
    logic        overflow;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic        fwdHit1;
    logic        fwdHit2;
    logic [31:0] fwdData1;
    logic [31:0] fwdData2;

    wb_t sb[$];
    int  n_vec;
    int  n_err;

    writeback_queue dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .memValid   (memValid),
        .memRd      (memRd),
        .memData    (memData),
        .aluValid   (aluValid),
        .aluRd      (aluRd),
        .aluData    (aluData),
        .wbStall    (wbStall),
        .inReady    (inReady),
        .regWrite   (regWrite),
        .writeRegId (writeRegId),
        .writeData  (writeData),
        .overflow   (overflow),
        .readReg1   (readReg1),
        .readReg2   (readReg2),
        .fwdHit1    (fwdHit1),
        .fwdHit2    (fwdHit2),
        .fwdData1   (fwdData1),
        .fwdData2   (fwdData2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        memValid = 1'b0; memRd = 5'd0; memData = 32'd0;
        aluValid = 1'b0; aluRd = 5'd0; aluData = 32'd0;
    endtask

    task automatic push_mem(input logic [4:0] rd, input logic [31:0] d, input bit expect_accept);
        memValid = 1'b1; memRd = rd; memData = d;
        if (expect_accept) sb.push_back('{rd: rd, data: d});
    endtask

    task automatic push_alu(input logic [4:0] rd, input logic [31:0] d, input bit expect_accept);
        aluValid = 1'b1; aluRd = rd; aluData = d;
        if (expect_accept) sb.push_back('{rd: rd, data: d});
    endtask

    // Monitor: each cycle with an active write must match the oldest expected entry.
    initial begin
        wb_t e;
        forever begin
            @(negedge clock);
            if (reset_n && regWrite) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write",
                             writeRegId, writeData);
                end else begin
                    e = sb.pop_front();
                    if (writeRegId !== e.rd || writeData !== e.data) begin
                        n_err++;
                        $display("FAIL write_order: got rd=%0d data=0x%0h, expected rd=%0d data=0x%0h",
                                 writeRegId, writeData, e.rd, e.data);
                    end
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n  = 1'b0;
        wbStall  = 1'b0;
        readReg1 = 5'd0;
        readReg2 = 5'd0;
        idle_inputs();
        #2;
        chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("rst_writeRegId", {27'd0, writeRegId}, 32'd0);
        chk("rst_writeData", writeData, 32'd0);
        chk("rst_inReady", {31'd0, inReady}, 32'd1);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_fwdHit", {30'd0, fwdHit1, fwdHit2}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single push: written the very next cycle, then idle.
        push_alu(5'd5, 32'd50, 1'b1);
        tick();
        idle_inputs();
        chk("single_regWrite", {31'd0, regWrite}, 32'd1);
        chk("single_rd", {27'd0, writeRegId}, 32'd5);
        chk("single_data", writeData, 32'd50);
        tick();
        chk("single_drained", {31'd0, regWrite}, 32'd0);

        // Dual push: mem is older than ALU.
        push_mem(5'd3, 32'h11, 1'b1);
        push_alu(5'd4, 32'h22, 1'b1);
        tick();
        idle_inputs();
        tick();
        tick();
        chk("dual_drained", {31'd0, regWrite}, 32'd0);

        // Back-to-back pushes with simultaneous pops.
        for (int i = 0; i < 3; i++) begin
            push_alu(5'(20 + i), 32'hA0 + 32'(i), 1'b1);
            tick();
        end
        idle_inputs();
        tick();
        chk("stream_drained", {31'd0, regWrite}, 32'd0);

        // x0 requests are discarded silently.
        push_alu(5'd0, 32'd99, 1'b0);
        tick();
        idle_inputs();
        chk("x0_regWrite", {31'd0, regWrite}, 32'd0);
        chk("x0_overflow", {31'd0, overflow}, 32'd0);
        chk("x0_inReady", {31'd0, inReady}, 32'd1);

        // Stall and fill, overflow on a push while full.
        wbStall = 1'b1;
        push_mem(5'd10, 32'h100, 1'b1);
        push_alu(5'd11, 32'h101, 1'b1);
        tick();
        chk("fill2_inReady", {31'd0, inReady}, 32'd1);
        chk("fill2_stalled", {31'd0, regWrite}, 32'd0);
        push_mem(5'd12, 32'h102, 1'b1);
        push_alu(5'd13, 32'h103, 1'b1);
        tick();
        idle_inputs();
        chk("fill4_inReady", {31'd0, inReady}, 32'd0);
        chk("fill4_overflow", {31'd0, overflow}, 32'd0);
        push_alu(5'd7, 32'h77, 1'b0);
        tick();
        idle_inputs();
        chk("drop_overflow", {31'd0, overflow}, 32'd1);
        chk("drop_inReady", {31'd0, inReady}, 32'd0);
        chk("stall_head_rd", {27'd0, writeRegId}, 32'd10);
        wbStall = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("fill_drained", {31'd0, regWrite}, 32'd0);
        chk("fill_inReady", {31'd0, inReady}, 32'd1);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Forwarding lookup over stored entries.
        wbStall = 1'b1;
        push_alu(5'd9, 32'hA, 1'b1);
        tick();
        push_alu(5'd9, 32'hB, 1'b1);
        tick();
        idle_inputs();
        readReg1 = 5'd9;
        readReg2 = 5'd0;
        #1;
`ifdef WRITEBACK_QUEUE_FORWARDING_EN
        chk("fwd1_hit", {31'd0, fwdHit1}, 32'd1);
        chk("fwd1_data", fwdData1, 32'hB);
        chk("fwd2_x0_hit", {31'd0, fwdHit2}, 32'd0);
        readReg2 = 5'd6;
        #1;
        chk("fwd2_miss_hit", {31'd0, fwdHit2}, 32'd0);
`else
        chk("fwd1_tied_hit", {31'd0, fwdHit1}, 32'd0);
        chk("fwd1_tied_data", fwdData1, 32'd0);
        chk("fwd2_tied", {31'd0, fwdHit2}, 32'd0);
`endif
        wbStall = 1'b0;
        tick();
        tick();
        chk("fwd_drained", {31'd0, regWrite}, 32'd0);
        readReg1 = 5'd0;

        // Reset mid-operation with three entries queued.
        wbStall = 1'b1;
        push_mem(5'd21, 32'h210, 1'b1);
        push_alu(5'd22, 32'h220, 1'b1);
        tick();
        idle_inputs();
        push_alu(5'd23, 32'h230, 1'b1);
        tick();
        idle_inputs();
        wbStall = 1'b0;
        #1;
        chk("pre_rst_regWrite", {31'd0, regWrite}, 32'd1);
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        #4;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_regWrite", {31'd0, regWrite}, 32'd0);
        end
        chk("post_rst_inReady", {31'd0, inReady}, 32'd1);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
